// File: rtl/raster_core_zp.sv
// Triangle rasterizer: walks a clipped bounding box with incremental edge functions,
// interpolates depth, tests it against an external z-buffer and writes colour; also clears the z-buffer.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start (ignored while done is still visible)
// SETUP_MUL | a_k*xi and b_k*yi products
// SETUP_SUM | e_k = a_k*xi + b_k*yi + c_k at the row start
// ROW       | load row edge values, x <= xi
// TEST      | inside test; outside pixels step x in one cycle
// ZMUL      | zacc = sum e_row_k*z_k
// ZSCALE    | z = sat((zacc*inv_area) >>> FRAC), issue z-buffer address
// ZREAD     | zb_rd high; read data lands next cycle
// ZCMP      | depth compare, write strobes, step x
// NEXT      | step y or finish
// CLEAR     | fill z-buffer with all-ones, one address per cycle
// DONE      | one-cycle done pulse follows
module raster_core_zp #(
  parameter int SCR_W = 320,
  parameter int SCR_H = 240,
  parameter int XW    = 9,
  parameter int YW    = 8,
  parameter int ZW    = 8,
  parameter int CW    = 16,
  parameter int AW    = 17,
  parameter int FRAC  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic                 zt_en_i,
  input  logic                 zw_en_i,
  input  logic signed [CW-1:0] a1_i,
  input  logic signed [CW-1:0] b1_i,
  input  logic signed [CW-1:0] c1_i,
  input  logic signed [CW-1:0] a2_i,
  input  logic signed [CW-1:0] b2_i,
  input  logic signed [CW-1:0] c2_i,
  input  logic signed [CW-1:0] a3_i,
  input  logic signed [CW-1:0] b3_i,
  input  logic signed [CW-1:0] c3_i,
  input  logic [ZW-1:0]        z1_i,
  input  logic [ZW-1:0]        z2_i,
  input  logic [ZW-1:0]        z3_i,
  input  logic [31:0]          inv_area_i,
  input  logic [7:0]           color_i,
  input  logic [XW-1:0]        bbxi_i,
  input  logic [XW-1:0]        bbxf_i,
  input  logic [YW-1:0]        bbyi_i,
  input  logic [YW-1:0]        bbyf_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fb_we_o,
  output logic [AW-1:0]        fb_addr_o,
  output logic [7:0]           fb_data_o,
  output logic [AW-1:0]        zb_addr_o,
  output logic                 zb_rd_o,
  input  logic [ZW-1:0]        zb_rdata_i,
  output logic                 zb_we_o,
  output logic [ZW-1:0]        zb_wdata_o
);

  localparam int EW  = CW + XW + 2;
  localparam int ZAW = EW + ZW + 2;
  localparam int PW  = ZAW + 33;
  localparam logic [AW-1:0] LAST_PIX = AW'(SCR_W * SCR_H - 1);

  typedef enum logic [3:0] {
    IDLE, SETUP_MUL, SETUP_SUM, ROW, TEST, ZMUL, ZSCALE, ZREAD, ZCMP, NEXT, CLEAR, DONE
  } state_t;

  state_t               state_q;
  logic                 busy_q, done_q, zb_rd_q, clr_we_q;
  logic                 zt_en_q, zw_en_q;
  logic [AW-1:0]        fb_addr_q, zb_addr_q;
  logic [7:0]           fb_data_q, color_q;
  logic [ZW-1:0]        zb_wdata_q;
  logic signed [CW-1:0] a_q [3];
  logic signed [CW-1:0] b_q [3];
  logic signed [CW-1:0] c_q [3];
  logic [ZW-1:0]        z_q [3];
  logic [31:0]          inv_q;
  logic [XW-1:0]        xi_q, xf_q, x_q;
  logic [YW-1:0]        yf_q, y_q;
  logic signed [EW-1:0] pa_q [3];
  logic signed [EW-1:0] pb_q [3];
  logic signed [EW-1:0] e_q [3];
  logic signed [EW-1:0] e_row_q [3];
  logic signed [ZAW-1:0] zacc_q;

  logic [XW-1:0]         xf_clip_d;
  logic [YW-1:0]         yf_clip_d;
  logic                  box_empty_d, inside_d, pass_d, zcmp_d;
  logic [AW-1:0]         pix_addr_d;
  logic signed [ZAW-1:0] zacc_d;
  logic signed [PW-1:0]  zprod_d, zshift_d;
  logic [ZW-1:0]         z_sat_d;

  always_comb begin
    xf_clip_d   = (bbxf_i > XW'(SCR_W - 1)) ? XW'(SCR_W - 1) : bbxf_i;
    yf_clip_d   = (bbyf_i > YW'(SCR_H - 1)) ? YW'(SCR_H - 1) : bbyf_i;
    box_empty_d = (bbxi_i > xf_clip_d) || (bbyi_i > yf_clip_d);
    inside_d    = !e_row_q[0][EW-1] && !e_row_q[1][EW-1] && !e_row_q[2][EW-1];
    pix_addr_d  = AW'(y_q) * AW'(SCR_W) + AW'(x_q);

    zacc_d = ZAW'(e_row_q[0]) * ZAW'($signed({1'b0, z_q[0]}))
           + ZAW'(e_row_q[1]) * ZAW'($signed({1'b0, z_q[1]}))
           + ZAW'(e_row_q[2]) * ZAW'($signed({1'b0, z_q[2]}));

    zprod_d  = PW'(zacc_q) * PW'($signed({1'b0, inv_q}));
    zshift_d = zprod_d >>> FRAC;
    if (zshift_d[PW-1])
      z_sat_d = '0;
    else if (|zshift_d[PW-2:ZW])
      z_sat_d = '1;
    else
      z_sat_d = zshift_d[ZW-1:0];

    // Read data is consumed combinationally so the write strobe lands in the ZCMP cycle.
    pass_d = !zt_en_q || (zb_wdata_q < zb_rdata_i);
    zcmp_d = (state_q == ZCMP) && pass_d;
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign zb_rd_o    = zb_rd_q;
  assign fb_we_o    = zcmp_d;
  assign zb_we_o    = clr_we_q || (zcmp_d && zw_en_q);
  assign fb_addr_o  = fb_addr_q;
  assign fb_data_o  = fb_data_q;
  assign zb_addr_o  = zb_addr_q;
  assign zb_wdata_o = zb_wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zb_rd_q    <= 1'b0;
      clr_we_q   <= 1'b0;
      zt_en_q    <= 1'b0;
      zw_en_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      zb_addr_q  <= '0;
      zb_wdata_q <= '0;
    end else begin
      done_q  <= 1'b0;
      zb_rd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && !done_q) begin
            busy_q  <= 1'b1;
            zt_en_q <= zt_en_i;
            zw_en_q <= zw_en_i;
            color_q <= color_i;
            inv_q   <= inv_area_i;
            a_q[0] <= a1_i; b_q[0] <= b1_i; c_q[0] <= c1_i;
            a_q[1] <= a2_i; b_q[1] <= b2_i; c_q[1] <= c2_i;
            a_q[2] <= a3_i; b_q[2] <= b3_i; c_q[2] <= c3_i;
            z_q[0] <= z1_i; z_q[1] <= z2_i; z_q[2] <= z3_i;
            xi_q <= bbxi_i;
            xf_q <= xf_clip_d;
            y_q  <= bbyi_i;
            yf_q <= yf_clip_d;
            if (mode_i) begin
              zb_addr_q  <= '0;
              zb_wdata_q <= '1;
              clr_we_q   <= 1'b1;
              state_q    <= CLEAR;
            end else if (box_empty_d) begin
              state_q <= DONE;
            end else begin
              state_q <= SETUP_MUL;
            end
          end
        end
        SETUP_MUL: begin
          for (int k = 0; k < 3; k++) begin
            pa_q[k] <= EW'(a_q[k]) * EW'($signed({1'b0, xi_q}));
            pb_q[k] <= EW'(b_q[k]) * EW'($signed({1'b0, y_q}));
          end
          state_q <= SETUP_SUM;
        end
        SETUP_SUM: begin
          for (int k = 0; k < 3; k++)
            e_q[k] <= pa_q[k] + pb_q[k] + EW'(c_q[k]);
          state_q <= ROW;
        end
        ROW: begin
          for (int k = 0; k < 3; k++)
            e_row_q[k] <= e_q[k];
          x_q     <= xi_q;
          state_q <= TEST;
        end
        TEST: begin
          if (inside_d) begin
            state_q <= ZMUL;
          end else if (x_q == xf_q) begin
            state_q <= NEXT;
          end else begin
            for (int k = 0; k < 3; k++)
              e_row_q[k] <= e_row_q[k] + EW'(a_q[k]);
            x_q <= x_q + XW'(1);
          end
        end
        ZMUL: begin
          zacc_q  <= zacc_d;
          state_q <= ZSCALE;
        end
        ZSCALE: begin
          zb_wdata_q <= z_sat_d;
          zb_addr_q  <= pix_addr_d;
          fb_addr_q  <= pix_addr_d;
          fb_data_q  <= color_q;
          zb_rd_q    <= 1'b1;
          state_q    <= ZREAD;
        end
        ZREAD: state_q <= ZCMP;
        ZCMP: begin
          if (x_q == xf_q) begin
            state_q <= NEXT;
          end else begin
            for (int k = 0; k < 3; k++)
              e_row_q[k] <= e_row_q[k] + EW'(a_q[k]);
            x_q     <= x_q + XW'(1);
            state_q <= TEST;
          end
        end
        NEXT: begin
          if (y_q == yf_q) begin
            state_q <= DONE;
          end else begin
            for (int k = 0; k < 3; k++)
              e_q[k] <= e_q[k] + EW'(b_q[k]);
            y_q     <= y_q + YW'(1);
            state_q <= ROW;
          end
        end
        CLEAR: begin
          if (zb_addr_q == LAST_PIX) begin
            clr_we_q <= 1'b0;
            state_q  <= DONE;
          end else begin
            zb_addr_q <= zb_addr_q + AW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_core_zp.sv
// Directed bench for raster_core_zp: z-buffer model, per-scenario tasks with inline checks.
module tb_raster_core_zp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0, mode_i = 1'b0, zt_en_i = 1'b0, zw_en_i = 1'b0;
  logic signed [15:0] a1_i = '0, b1_i = '0, c1_i = '0;
  logic signed [15:0] a2_i = '0, b2_i = '0, c2_i = '0;
  logic signed [15:0] a3_i = '0, b3_i = '0, c3_i = '0;
  logic [7:0]  z1_i = '0, z2_i = '0, z3_i = '0;
  logic [31:0] inv_area_i = '0;
  logic [7:0]  color_i = '0;
  logic [8:0]  bbxi_i = '0, bbxf_i = '0;
  logic [7:0]  bbyi_i = '0, bbyf_i = '0;
  logic        busy_o, done_o, fb_we_o, zb_rd_o, zb_we_o;
  logic [16:0] fb_addr_o, zb_addr_o;
  logic [7:0]  fb_data_o, zb_wdata_o;
  logic [7:0]  zb_rdata_i = '0;

  raster_core_zp dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .zt_en_i(zt_en_i), .zw_en_i(zw_en_i),
    .a1_i(a1_i), .b1_i(b1_i), .c1_i(c1_i),
    .a2_i(a2_i), .b2_i(b2_i), .c2_i(c2_i),
    .a3_i(a3_i), .b3_i(b3_i), .c3_i(c3_i),
    .z1_i(z1_i), .z2_i(z2_i), .z3_i(z3_i),
    .inv_area_i(inv_area_i), .color_i(color_i),
    .bbxi_i(bbxi_i), .bbxf_i(bbxf_i), .bbyi_i(bbyi_i), .bbyf_i(bbyf_i),
    .busy_o(busy_o), .done_o(done_o), .fb_we_o(fb_we_o),
    .fb_addr_o(fb_addr_o), .fb_data_o(fb_data_o),
    .zb_addr_o(zb_addr_o), .zb_rd_o(zb_rd_o), .zb_rdata_i(zb_rdata_i),
    .zb_we_o(zb_we_o), .zb_wdata_o(zb_wdata_o)
  );

  always #5 clk = ~clk;

  logic [7:0] zmem [0:76799];
  always @(posedge clk) begin
    if (zb_rd_o && zb_addr_o < 17'd76800) zb_rdata_i <= zmem[zb_addr_o];
    if (zb_we_o && zb_addr_o < 17'd76800) zmem[zb_addr_o] <= zb_wdata_o;
  end

  int checks = 0;
  int failures = 0;

  logic [16:0] fb_addr_log[$];
  logic [7:0]  fb_data_log[$];
  logic [16:0] zw_addr_log[$];
  logic [7:0]  zw_data_log[$];
  int done_cnt, busy_cnt, zrd_cnt, overlap_cnt, first_fb, first_rd, cyc_to_done;
  bit timed_out;

  task automatic set_box(input logic [8:0] xi, input logic [8:0] xf,
                         input logic [7:0] yi, input logic [7:0] yf);
    bbxi_i = xi; bbxf_i = xf; bbyi_i = yi; bbyf_i = yf;
  endtask

  task automatic set_coef(input logic signed [15:0] a1, b1, c1, a2, b2, c2, a3, b3, c3);
    a1_i = a1; b1_i = b1; c1_i = c1;
    a2_i = a2; b2_i = b2; c2_i = c2;
    a3_i = a3; b3_i = b3; c3_i = c3;
  endtask

  task automatic set_misc(input bit mode, input bit zt, input bit zw, input logic [7:0] z1,
                          input logic [7:0] z2, input logic [7:0] z3,
                          input logic [31:0] inv, input logic [7:0] col);
    mode_i = mode; zt_en_i = zt; zw_en_i = zw;
    z1_i = z1; z2_i = z2; z3_i = z3; inv_area_i = inv; color_i = col;
  endtask

  // Leaves the bench at the first negedge after the accepting edge.
  task automatic issue();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Index 0 is the first cycle after the accepting edge.
  task automatic collect(input int budget, input int poke_at);
    fb_addr_log.delete(); fb_data_log.delete();
    zw_addr_log.delete(); zw_data_log.delete();
    done_cnt = 0; busy_cnt = 0; zrd_cnt = 0; overlap_cnt = 0;
    first_fb = -1; first_rd = -1; cyc_to_done = -1; timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (fb_we_o) begin
        fb_addr_log.push_back(fb_addr_o);
        fb_data_log.push_back(fb_data_o);
        if (first_fb < 0) first_fb = i;
      end
      if (zb_we_o) begin
        zw_addr_log.push_back(zb_addr_o);
        zw_data_log.push_back(zb_wdata_o);
      end
      if (zb_rd_o) begin
        zrd_cnt++;
        if (first_rd < 0) first_rd = i;
      end
      if ((fb_we_o && zb_rd_o) || (zb_we_o && zb_rd_o)) overlap_cnt++;
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        if (cyc_to_done < 0) cyc_to_done = i;
      end
      if (cyc_to_done >= 0 && i >= cyc_to_done + 3) begin
        timed_out = 1'b0;
        break;
      end
      start_i = (i == poke_at);
      if (i == poke_at) mode_i = 1'b1;
      @(negedge clk);
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, done_o, fb_we_o, zb_we_o, zb_rd_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=00000", {busy_o, done_o, fb_we_o, zb_we_o, zb_rd_o});
    end
    checks++;
    if ({fb_addr_o, zb_addr_o} !== 34'd0) begin
      failures++;
      $display("FAIL reset_addr got fb=%0d zb=%0d exp=0", fb_addr_o, zb_addr_o);
    end
    checks++;
    if ({fb_data_o, zb_wdata_o} !== 16'd0) begin
      failures++;
      $display("FAIL reset_data got fb=%0h zb=%0h exp=0", fb_data_o, zb_wdata_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_clear();
    bit found = 1'b0;
    int bad = 0;
    set_misc(1'b1, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 32'h0, 8'h0);
    issue();
    for (int i = 0; i < 300; i++) begin
      if (zb_we_o && zb_addr_o == 17'd100) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midclr_reach100 got=not_seen exp=zb_we at addr 100");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({zb_we_o, fb_we_o, zb_rd_o, busy_o, done_o} !== 5'b0) begin
      failures++;
      $display("FAIL midclr_abort got=%b exp=00000", {zb_we_o, fb_we_o, zb_rd_o, busy_o, done_o});
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_o || zb_we_o || busy_o) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL midclr_quiet got=%0d active cycles exp=0", bad);
    end
    // one-pixel draw: e_k=1 each, z=3*0x10*1.0=0x30 at (2,3)
    set_box(9'd2, 9'd2, 8'd3, 8'd3);
    set_coef(16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd1);
    set_misc(1'b0, 1'b0, 1'b1, 8'h10, 8'h10, 8'h10, 32'h0100_0000, 8'h5A);
    issue();
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL postrst_busy got=%b exp=1", busy_o);
    end
    collect(200, -1);
    checks++;
    if (timed_out || done_cnt !== 1) begin
      failures++;
      $display("FAIL postrst_done got=%0d timeout=%0d exp=1", done_cnt, timed_out);
    end
    checks++;
    if (fb_addr_log.size() !== 1 || fb_addr_log[0] !== 17'd962 || fb_data_log[0] !== 8'h5A) begin
      failures++;
      $display("FAIL postrst_fb got n=%0d exp n=1 addr=962 data=5a", fb_addr_log.size());
    end
    checks++;
    if (zw_addr_log.size() !== 1 || zw_data_log[0] !== 8'h30) begin
      failures++;
      $display("FAIL postrst_zw got n=%0d exp n=1 data=30", zw_addr_log.size());
    end
  endtask

  task automatic test_clear();
    int bad = 0;
    set_misc(1'b1, 1'b1, 1'b1, 8'h0, 8'h0, 8'h0, 32'h0, 8'h0);
    issue();
    collect(80000, -1);
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL clear_timeout got=no_done exp=done");
    end
    checks++;
    if (zw_addr_log.size() !== 76800) begin
      failures++;
      $display("FAIL clear_count got=%0d exp=76800", zw_addr_log.size());
    end
    for (int i = 0; i < zw_addr_log.size(); i++)
      if (zw_addr_log[i] !== 17'(i) || zw_data_log[i] !== 8'hFF) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL clear_seq got=%0d bad entries exp=0", bad);
    end
    checks++;
    if (fb_addr_log.size() !== 0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL clear_fb_done got fb=%0d done=%0d exp fb=0 done=1", fb_addr_log.size(), done_cnt);
    end
    checks++;
    if (busy_cnt !== 76801) begin
      failures++;
      $display("FAIL clear_busy got=%0d exp=76801", busy_cnt);
    end
  endtask

  // Triangle (0,0),(7,0),(0,7): e1=x, e2=y, e3=7-x-y; inv_area=ceil(2^24/7) gives z=0x40.
  task automatic load_triangle(input bit zt, input bit zw);
    set_box(9'd0, 9'd7, 8'd0, 8'd7);
    set_coef(16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd0, -16'sd1, -16'sd1, 16'sd7);
    set_misc(1'b0, zt, zw, 8'h40, 8'h40, 8'h40, 32'd2396746, 8'hA5);
  endtask

  task automatic test_triangle();
    logic [16:0] exp_q[$];
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (x + y <= 7) exp_q.push_back(17'(y * 320 + x));
    load_triangle(1'b1, 1'b1);
    issue();
    collect(3000, -1);
    checks++;
    if (timed_out || done_cnt !== 1) begin
      failures++;
      $display("FAIL tri_done got=%0d timeout=%0d exp=1", done_cnt, timed_out);
    end
    checks++;
    if (fb_addr_log.size() !== 36 || zw_addr_log.size() !== 36) begin
      failures++;
      $display("FAIL tri_count got fb=%0d zw=%0d exp=36", fb_addr_log.size(), zw_addr_log.size());
    end
    for (int i = 0; i < 36 && i < fb_addr_log.size() && i < zw_addr_log.size(); i++) begin
      checks++;
      if (fb_addr_log[i] !== exp_q[i] || fb_data_log[i] !== 8'hA5 ||
          zw_addr_log[i] !== exp_q[i] || zw_data_log[i] !== 8'h40) begin
        failures++;
        $display("FAIL tri_pix%0d got fb=%0d/%0h zb=%0d/%0h exp=%0d a5/40", i,
                 fb_addr_log[i], fb_data_log[i], zw_addr_log[i], zw_data_log[i], exp_q[i]);
      end
    end
    checks++;
    if (first_rd !== 6 || first_fb !== 7) begin
      failures++;
      $display("FAIL tri_latency got rd=%0d we=%0d exp rd=6 we=7", first_rd, first_fb);
    end
    checks++;
    if (overlap_cnt !== 0) begin
      failures++;
      $display("FAIL tri_overlap got=%0d exp=0", overlap_cnt);
    end
    checks++;
    if (zmem[2240] !== 8'h40 || zmem[2241] !== 8'hFF) begin
      failures++;
      $display("FAIL tri_zmem got=%0h/%0h exp=40/ff", zmem[2240], zmem[2241]);
    end
  endtask

  task automatic test_ties();
    load_triangle(1'b1, 1'b1);
    issue();
    collect(3000, -1);
    checks++;
    if (timed_out || done_cnt !== 1) begin
      failures++;
      $display("FAIL ties_done got=%0d timeout=%0d exp=1", done_cnt, timed_out);
    end
    checks++;
    if (fb_addr_log.size() !== 0 || zw_addr_log.size() !== 0) begin
      failures++;
      $display("FAIL ties_writes got fb=%0d zw=%0d exp=0", fb_addr_log.size(), zw_addr_log.size());
    end
    checks++;
    if (zrd_cnt !== 36) begin
      failures++;
      $display("FAIL ties_reads got=%0d exp=36", zrd_cnt);
    end
  endtask

  task automatic test_no_depth();
    load_triangle(1'b0, 1'b0);
    issue();
    collect(3000, -1);
    checks++;
    if (timed_out || fb_addr_log.size() !== 36 || zw_addr_log.size() !== 0) begin
      failures++;
      $display("FAIL nodepth_count got fb=%0d zw=%0d exp fb=36 zw=0", fb_addr_log.size(), zw_addr_log.size());
    end
    checks++;
    if (fb_addr_log.size() == 0 || fb_addr_log[fb_addr_log.size()-1] !== 17'd2240) begin
      failures++;
      $display("FAIL nodepth_last got n=%0d exp last addr=2240", fb_addr_log.size());
    end
  endtask

  task automatic test_clip();
    logic [16:0] exp_q[$];
    for (int y = 238; y <= 239; y++)
      for (int x = 316; x <= 319; x++) exp_q.push_back(17'(y * 320 + x));
    set_box(9'd316, 9'd400, 8'd238, 8'd250);
    set_coef(16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd1);
    set_misc(1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 32'h0, 8'h33);
    issue();
    collect(500, -1);
    checks++;
    if (timed_out || fb_addr_log.size() !== 8) begin
      failures++;
      $display("FAIL clip_count got=%0d timeout=%0d exp=8", fb_addr_log.size(), timed_out);
    end
    for (int i = 0; i < 8 && i < fb_addr_log.size(); i++) begin
      checks++;
      if (fb_addr_log[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL clip_pix%0d got=%0d exp=%0d", i, fb_addr_log[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_empty_box();
    int bad = 0;
    set_box(9'd5, 9'd3, 8'd0, 8'd3);
    set_misc(1'b0, 1'b0, 1'b1, 8'h0, 8'h0, 8'h0, 32'h0, 8'h11);
    issue();
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL empty_busy got busy=%b done=%b exp busy=1 done=0", busy_o, done_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b1) begin
      failures++;
      $display("FAIL empty_done got busy=%b done=%b exp busy=0 done=1", busy_o, done_o);
    end
    // start coincident with done must be ignored
    mode_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL start_on_done got busy=%b exp=0", busy_o);
    end
    for (int i = 0; i < 3; i++) begin
      if (busy_o || fb_we_o || zb_we_o || zb_rd_o || done_o) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL empty_quiet got=%0d active cycles exp=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    set_box(9'd0, 9'd3, 8'd0, 8'd3);
    set_coef(16'sd0, 16'sd0, -16'sd1, 16'sd0, 16'sd0, -16'sd1, 16'sd0, 16'sd0, -16'sd1);
    set_misc(1'b0, 1'b0, 1'b1, 8'h0, 8'h0, 8'h0, 32'h0, 8'h77);
    issue();
    collect(300, 5);
    checks++;
    if (timed_out || done_cnt !== 1) begin
      failures++;
      $display("FAIL outside_done got=%0d timeout=%0d exp=1", done_cnt, timed_out);
    end
    checks++;
    if (fb_addr_log.size() !== 0 || zw_addr_log.size() !== 0 || zrd_cnt !== 0) begin
      failures++;
      $display("FAIL outside_strobes got fb=%0d zw=%0d rd=%0d exp=0", fb_addr_log.size(), zw_addr_log.size(), zrd_cnt);
    end
    checks++;
    if (busy_cnt !== 27 || cyc_to_done !== 27) begin
      failures++;
      $display("FAIL outside_cycles got busy=%0d done_at=%0d exp=27/27", busy_cnt, cyc_to_done);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_clear();
    test_clear();
    test_triangle();
    test_ties();
    test_no_depth();
    test_clip();
    test_empty_box();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
